// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: EX/MEM payload layout, its NOP bubble and the
// skid stage state encoding.
package pipe_pkg;

  localparam int RESULT_W  = 32;
  localparam int OP2_W     = 32;
  localparam int MEM_WE_W  = 1;
  localparam int LD_TYPE_W = 3;
  localparam int ST_TYPE_W = 2;
  localparam int WB_LOAD_W = 1;
  localparam int WB_REG_W  = 1;
  localparam int RD_W      = 5;

  localparam int EXMEM_W = RESULT_W + OP2_W + MEM_WE_W + LD_TYPE_W +
                           ST_TYPE_W + WB_LOAD_W + WB_REG_W + RD_W;

  typedef struct packed {
    logic [RESULT_W-1:0]  result;
    logic [OP2_W-1:0]     op2;
    logic [MEM_WE_W-1:0]  mem_we;
    logic [LD_TYPE_W-1:0] ld_type;
    logic [ST_TYPE_W-1:0] st_type;
    logic [WB_LOAD_W-1:0] wb_load;
    logic [WB_REG_W-1:0]  wb_reg;
    logic [RD_W-1:0]      rd;
  } exmem_t;

  // All-ones load/store types decode as "no memory access" downstream.
  localparam exmem_t EXMEM_NOP = '{
    result:  '0,
    op2:     '0,
    mem_we:  '0,
    ld_type: 3'b111,
    st_type: 2'b11,
    wb_load: '0,
    wb_reg:  '0,
    rd:      '0
  };

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage: a main register feeding out_data plus one skid
// register, so in_ready can be fully registered while still streaming at 1/cycle.
//
// state    | meaning
// ST_EMPTY | no entry held, out_data = BUBBLE
// ST_ONE   | main holds the head entry
// ST_FULL  | main holds the head, skid holds the next entry
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W = EXMEM_W,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              accept, consume;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          main_d = in_data;
        end else if (consume) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so no accept can race the skid-to-main move.
        if (consume) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        main_d  = BUBBLE;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
    end
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    out_data  = main_q;
    occupancy = state_q;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a reference-queue scoreboard checked every cycle
// by a monitor, plus directed checks with hand-computed values.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int W = EXMEM_W;
  localparam logic [W-1:0] BUB = EXMEM_NOP;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occupancy;

  pipe_stage_skid #(.DATA_W(W), .BUBBLE(EXMEM_NOP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int           n_chk  = 0;
  int           n_pass = 0;
  bit           mon_en = 1'b1;
  logic [W-1:0] ref_q[$];
  bit           ref_rdy = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue of at most two entries, ready when the
  // queue will not be full after this edge.
  always @(negedge clk) begin
    if (mon_en) begin
      int  occ;
      bit  acc, con;
      if (!rst_n) begin
        ref_q.delete();
        ref_rdy = 1'b0;
      end
      occ = ref_q.size();
      chk("out_valid", W'(out_valid), W'(occ > 0));
      chk("in_ready", W'(in_ready), W'(ref_rdy));
      chk("occupancy", W'(occupancy), W'(occ));
      chk("out_data", out_data, (occ > 0) ? ref_q[0] : BUB);
      if (rst_n) begin
        acc = in_valid && ref_rdy;
        con = (occ > 0) && out_ready;
        if (flush) begin
          ref_q.delete();
        end else begin
          if (con) void'(ref_q.pop_front());
          if (acc) ref_q.push_back(in_data);
        end
        ref_rdy = (ref_q.size() < 2);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exmem_t view;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_occupancy", W'(occupancy), W'(0));
    chk("rst_out_data", out_data, BUB);
    step();
    chk("ready_after_release", W'(in_ready), W'(1));

    view = exmem_t'(out_data);
    chk("nop_ld_type", W'(view.ld_type), W'(3'b111));
    chk("nop_st_type", W'(view.st_type), W'(2'b11));
    chk("nop_mem_we", W'(view.mem_we), W'(0));

    // Streaming 1..100
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in_data = W'(i);
      step();
      chk("stream_data", out_data, W'(i));
      chk("stream_occ", W'(occupancy), W'(1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", W'(occupancy), W'(0));

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'('hA);
    step();
    in_data = W'('hB);
    step();
    in_valid = 1'b0;
    chk("bp_occ_full", W'(occupancy), W'(2));
    chk("bp_ready_low", W'(in_ready), W'(0));
    chk("bp_head_a", out_data, W'('hA));
    out_ready = 1'b1;
    step();
    chk("bp_ready_back", W'(in_ready), W'(1));
    chk("bp_head_b", out_data, W'('hB));
    chk("bp_occ_one", W'(occupancy), W'(1));
    step();
    chk("bp_empty", W'(out_valid), W'(0));
    out_ready = 1'b0;

    // Flush collision from FULL
    in_valid = 1'b1; in_data = W'('hD1);
    step();
    in_data = W'('hD2);
    step();
    chk("fl_full", W'(occupancy), W'(2));
    flush = 1'b1; in_data = W'('hC);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", W'(out_valid), W'(0));
    chk("fl_data", out_data, BUB);
    chk("fl_occ", W'(occupancy), W'(0));
    chk("fl_ready", W'(in_ready), W'(1));

    // Flush colliding with a real accept in ONE
    in_valid = 1'b1; in_data = W'('hD3);
    step();
    flush = 1'b1; in_data = W'('hC);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_occ", W'(occupancy), W'(0));
    chk("fl1_data", out_data, BUB);
    step();
    chk("fl1_no_c", W'(out_valid), W'(0));

    // Asynchronous reset with two entries held
    in_valid = 1'b1; in_data = W'('hE1);
    step();
    in_data = W'('hE2);
    step();
    in_valid = 1'b0;
    chk("rst_mid_full", W'(occupancy), W'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", W'(out_valid), W'(0));
    chk("rst_mid_data", out_data, BUB);
    chk("rst_mid_ready", W'(in_ready), W'(0));
    chk("rst_mid_occ", W'(occupancy), W'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_mid_ready_hold", W'(in_ready), W'(0));
    step();
    chk("rst_mid_ready_rise", W'(in_ready), W'(1));

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = W'({$urandom, $urandom, $urandom});
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("final_empty", W'(occupancy), W'(0));

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL take parameter DATA_W, default 77, giving the payload width (EX/MEM bundle: result 32, op2 32, mem write 1, load type 3, store type 2, wb load 1, wb reg 1, rd 5).
REQ-002 The block SHALL take parameter BUBBLE, DATA_W bits, default all-zero, giving the payload driven when the stage holds no valid entry.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous kill of all held entries.
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  out_data is a live entry.
REQ-010 out_ready  input  1  downstream consumes this cycle.
REQ-011 out_data  output  DATA_W  head entry payload.
REQ-012 occupancy  output  2  number of held entries, 0..2.

Function
REQ-013 Accept event = in_valid & in_ready; consume event = out_valid & out_ready; both SHALL be evaluated on the same edge.
REQ-014 Storage SHALL be a main register (drives out_data) plus one skid register; states EMPTY (0 entries), ONE (main only), FULL (main + skid).
REQ-015 EMPTY: accept -> ONE, entry to main; out_valid rises the cycle after accept (latency 1).
REQ-016 ONE: accept & consume -> ONE, main replaced by in_data; consume only -> EMPTY; accept only -> FULL, entry to skid; neither -> ONE.
REQ-017 FULL: consume -> ONE, skid moves to main; no consume -> FULL, both held unchanged.
REQ-018 in_ready SHALL be a register equal to "next state is not FULL"; in_ready SHALL have no combinational path from out_ready or in_valid.
REQ-019 out_valid and out_data SHALL come directly from registers, no combinational path from any input.
REQ-020 Sustained in_valid=1, out_ready=1 SHALL yield one transfer per cycle, order preserved, no drop or duplicate.
REQ-021 When out_valid=0, out_data SHALL equal BUBBLE; skid contents when invalid are don't-care internally but never visible.
REQ-022 flush=1 SHALL on that edge move to EMPTY, set out_data=BUBBLE, and discard any same-cycle accepted entry; flush dominates accept and consume.
REQ-023 in_ready SHALL be 1 in the cycle after a flush.
REQ-024 A consume during FULL with simultaneous in_valid SHALL NOT accept (in_ready was 0); data held in skid SHALL NOT be overwritten.
REQ-025 occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL, registered.

Reset
REQ-026 rst_n low SHALL immediately force state EMPTY, out_valid=0, out_data=BUBBLE, occupancy=0, in_ready=0.
REQ-027 in_ready SHALL rise on the first clk edge after rst_n deasserts; no accept occurs while rst_n is low.
REQ-028 Reset asserted mid-operation SHALL discard all entries with no partial transfer visible downstream.

Structure
REQ-029 Payload field widths, DATA_W default and the EX/MEM NOP bubble constant (load type 3'b111, store type 2'b11, all else zero) SHALL live in shared package pipe_pkg.
REQ-030 The block SHALL be a single module with no sub-modules; existing fixed stage registers are replaced by instances of it.

Verification
REQ-031 Reset: rst_n low mid-stream with occupancy=2 -> out_valid=0, out_data=BUBBLE, in_ready=0 without clock; first edge after release -> in_ready=1.
REQ-032 Streaming: payloads 1..100 with in_valid=1, out_ready=1 -> out_data 1..100 in order, one per cycle, 1-cycle latency, occupancy constant 1.
REQ-033 Backpressure: push 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0; raise out_ready -> 0xA then 0xB, in_ready=1 after first consume.
REQ-034 Flush collision: FULL state, flush=1 with in_valid=1, data 0xC -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0; 0xC never appears.
REQ-035 Random: random in_valid/out_ready at 50% for 10000 cycles, scoreboard vs reference queue -> zero mismatches, occupancy never exceeds 2.
REQ-036 Bubble override: BUBBLE=pipe_pkg NOP constant, idle stage -> load type field 3'b111, store type 2'b11, write 0.
